// File: rtl/writeback_unit.sv
// writeback_unit: queues ALU/load results and retires one register
// file write per clock, with two combinational forwarding lookups.
module writeback_unit #(
  parameter int DEPTH = 2
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [31:0]              alu_data,
  output logic                     alu_ready,
  input  logic                     ld_valid,
  input  logic [4:0]               ld_rd,
  input  logic [31:0]              ld_data,
  output logic                     ld_ready,
  output logic [4:0]               RD,
  output logic [31:0]              RD_DATA,
  output logic                     reg_write_enable,
  input  logic [4:0]               R1,
  input  logic [4:0]               R2,
  output logic                     R1_fwd_hit,
  output logic                     R2_fwd_hit,
  output logic [31:0]              R1_fwd_data,
  output logic [31:0]              R2_fwd_data,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    r_rd_q   [DEPTH];
  logic [31:0]   r_dat_q  [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [4:0]    r_rd;
  logic [31:0]   r_rd_data;
  logic          r_we;

  logic          w_full;
  logic          w_empty;
  logic          w_ld_acc;
  logic          w_alu_acc;
  logic [4:0]    w_in_rd;
  logic [31:0]   w_in_data;
  logic          w_push;
  logic          w_pop;

  logic [4:0]    w_faddr [2];
  logic          w_fhit  [2];
  logic [31:0]   w_fdat  [2];
  logic [PW-1:0] w_idx;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign ld_ready  = !w_full;
  assign alu_ready = !w_full && !ld_valid;

  assign w_ld_acc  = ld_valid && ld_ready;
  assign w_alu_acc = alu_valid && alu_ready;
  assign w_in_rd   = w_ld_acc ? ld_rd : alu_rd;
  assign w_in_data = w_ld_acc ? ld_data : alu_data;
  // x0 writes finish the handshake but are dropped here
  assign w_push    = (w_ld_acc || w_alu_acc) && (w_in_rd != 5'd0);
  assign w_pop     = !w_empty;

  // FIFO storage, pointers and occupancy
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_rd_q[i]  <= '0;
        r_dat_q[i] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_rd_q[r_tail]  <= w_in_rd;
        r_dat_q[r_tail] <= w_in_data;
        r_tail          <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Output stage: head moves to the write port whenever queued
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rd      <= '0;
      r_rd_data <= '0;
      r_we      <= 1'b0;
    end else if (w_pop) begin
      r_rd      <= r_rd_q[r_head];
      r_rd_data <= r_dat_q[r_head];
      r_we      <= 1'b1;
    end else begin
      r_we      <= 1'b0;
    end
  end

  assign w_faddr[0] = R1;
  assign w_faddr[1] = R2;

  // Forwarding: scan oldest to youngest so the youngest match wins
  always_comb begin
    w_idx = '0;
    for (int p = 0; p < 2; p++) begin
      w_fhit[p] = 1'b0;
      w_fdat[p] = '0;
      if (r_we && (r_rd == w_faddr[p])) begin
        w_fhit[p] = 1'b1;
        w_fdat[p] = r_rd_data;
      end
      for (int i = 0; i < DEPTH; i++) begin
        w_idx = r_head + PW'(i);
        if ((CW'(i) < r_count) && (r_rd_q[w_idx] == w_faddr[p])) begin
          w_fhit[p] = 1'b1;
          w_fdat[p] = r_dat_q[w_idx];
        end
      end
      if (w_faddr[p] == 5'd0) begin
        w_fhit[p] = 1'b0;
        w_fdat[p] = '0;
      end
    end
  end

  assign R1_fwd_hit       = w_fhit[0];
  assign R1_fwd_data      = w_fdat[0];
  assign R2_fwd_hit       = w_fhit[1];
  assign R2_fwd_data      = w_fdat[1];
  assign RD               = r_rd;
  assign RD_DATA          = r_rd_data;
  assign reg_write_enable = r_we;
  assign pending          = r_count;

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Write-side driver for the RV32I register file: it accepts completed results from the ALU and the load unit, queues them in a small FIFO and retires one register write per clock onto the register file write port (RD, RD_DATA, reg_write_enable). It also answers two combinational forwarding lookups, so decode sees results that are queued or being written but are not yet readable from the register file. It sits between execute/memory and the register file's write port.

## Interface
- DEPTH, 2, FIFO entries; power of two, ≥2.
- CLK  in  1  system clock; all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result present.
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- alu_ready  out  1  ALU result accepted this cycle when alu_valid is also high.
- ld_valid  in  1  load result present.
- ld_rd  in  5  load destination register.
- ld_data  in  32  load result.
- ld_ready  out  1  load result accepted this cycle when ld_valid is also high.
- RD  out  5  register file write address.
- RD_DATA  out  32  register file write data.
- reg_write_enable  out  1  register file write strobe.
- R1, R2  in  5 each  forwarding lookup addresses.
- R1_fwd_hit, R2_fwd_hit  out  1 each  a pending value exists for the lookup address.
- R1_fwd_data, R2_fwd_data  out  32 each  the forwarded value; 0 when there is no hit.
- pending  out  clog2(DEPTH)+1  FIFO occupancy.

## Operation
- **Acceptance:** at most one input per cycle.
  - ld_ready = !full.
  - alu_ready = !full && !ld_valid. Load has fixed priority.
  - Handshake completes when valid && ready are high at a rising edge.
- **x0 filter:** an accepted result with rd=0 completes its handshake but is discarded. It is not enqueued and never produces a write.
- **FIFO:**
  - Entry is {rd, data}; push at the tail, pop at the head, pointers wrap modulo DEPTH.
  - Push and pop in the same cycle is legal at any occupancy below DEPTH; occupancy is then unchanged.
  - Push when full cannot occur, because ready is low.
- **Retire:** on every edge where the FIFO is non-empty, pop the head into the output stage:
  - RD ← head.rd, RD_DATA ← head.data, reg_write_enable ← 1.
  - If the FIFO is empty: reg_write_enable ← 0; RD and RD_DATA hold their values.
- **Forwarding** (combinational, per port, shown for R1):
  - Candidates are all valid FIFO entries plus the output stage while reg_write_enable=1.
  - Hit when R1 ≠ 0 and any candidate's rd equals R1.
  - On multiple matches the youngest wins: FIFO tail-most entry, then older FIFO entries, then the output stage.
  - R1 = 0 always gives hit 0 and data 0.
- **Ordering:** register file writes occur in acceptance order; there is no reordering or merging.

## Timing
- **Reset** (asynchronous assert, takes effect immediately):
  - FIFO empty, pointers 0, pending=0.
  - RD=0, RD_DATA=0, reg_write_enable=0.
  - Fwd hits 0, fwd data 0.
  - ld_ready=1; alu_ready = !ld_valid.
- **Reset mid-operation:** all queued and in-flight writes are dropped; no write strobe occurs after reset asserts. Deassertion is synchronized by the system; the first accept is possible at the first edge after release.
- **Latency:**
  - A result accepted at edge k is in the FIFO and visible to forwarding during cycle k+1 (it is not visible in the same cycle it is accepted).
  - It reaches the output stage at edge k+1 if it is the head, so reg_write_enable is high during cycle k+1→k+2.
  - Each queued entry ahead of it adds one cycle.
- **Throughput:** one write per cycle sustained; with continuous input the FIFO never exceeds 1 entry.
- **Strobe width:** reg_write_enable is high for exactly one cycle per retired entry. Back-to-back writes give a continuous strobe with RD/RD_DATA changing each cycle.
- **Full:** ld_ready and alu_ready drop in the same cycle pending reaches DEPTH. This state is reachable only when the upstream presents inputs faster than retire can drain, i.e., when the DEPTH parameter is exercised by a stalled output in formal or bench-forced scenarios.

## Test plan
- **Reset values:** RST_N=0 mid-cycle → outputs go to reset values immediately. Then RST_N=1 with no input → reg_write_enable stays 0 and pending=0.
- **Single write:** ALU rd=1, data=5 accepted at edge k → pending=1 in cycle k+1; RD=1, RD_DATA=5, reg_write_enable=1 for exactly cycle k+1→k+2; then the strobe returns to 0.
- **Simultaneous sources:** ld(rd=2, 10) and alu(rd=3, 99) both valid → load accepted first with alu_ready=0; ALU accepted next cycle. Writes appear in order: RD=2/10, then RD=3/99.
- **x0 drop:** ALU rd=0, data=99 → alu_ready=1, pending stays 0, no strobe. R1=0 lookup → hit 0, data 0.
- **Forwarding priority:** accept rd=4/7, then rd=4/8 on consecutive edges; set R1=4 → hit=1 with data 7 in the first cycle, and data 8 once 8 is queued and younger. R2=5 → hit=0, data 0.
- **Reset mid-queue:** two writes pending, assert RST_N=0 → no further strobes. After release, a new ALU rd=6/1 write retires normally.
